// File: rtl/rom_reader.sv
// rom_reader: streams a contiguous, wrapping block of ROM words into a valid/ready FIFO output.
// Optional feature macro ROM_READER_PARITY_EN adds out_parity, an even-parity bit stored per word.
module rom_reader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef ROM_READER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

`ifdef ROM_READER_PARITY_EN
    localparam int unsigned FifoW = DATA_W + 2;
`else
    localparam int unsigned FifoW = DATA_W + 1;
`endif
    localparam logic [ADDR_W-1:0] AddrOne = 1;
    localparam logic [ADDR_W:0]   CntOne  = 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              last_s1_q, last_s1_d;
    logic              s2_q, s2_d;
    logic              last_s2_q, last_s2_d;
    logic [FifoW-1:0]  mem_q [4];
    logic [FifoW-1:0]  mem_d [4];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        occ;
    logic              room, push, pop;
    logic [FifoW-1:0]  wdata, head;

    // Output FIFO; the word and its last flag are captured in the s2 cycle.
    always_comb begin
        push = s2_q;
        pop  = (cnt_q != 3'd0) && out_ready;
`ifdef ROM_READER_PARITY_EN
        wdata = {^rom_data, last_s2_q, rom_data};
`else
        wdata = {last_s2_q, rom_data};
`endif
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
        end
        wr_ptr_d = wr_ptr_q + {1'b0, push};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        cnt_d    = cnt_q + {2'b0, push} - {2'b0, pop};
        s2_d      = rom_en_q;
        last_s2_d = last_s1_q;
    end

    // Conservative space check: words in flight are counted, pops this cycle are not.
    assign occ  = cnt_q + {2'b0, rom_en_q} + {2'b0, s2_q};
    assign room = occ < 3'd4;

    always_comb begin
        state_d    = state_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        nxt_addr_d = nxt_addr_q;
        rem_d      = rem_q;
        last_s1_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = StDone;
                    end else begin
                        rom_en_d   = 1'b1;
                        rom_addr_d = start_addr;
                        nxt_addr_d = start_addr + AddrOne;
                        rem_d      = count - CntOne;
                        last_s1_d  = (count == CntOne);
                        // A one-word block has nothing left to issue after this read.
                        state_d    = (count == CntOne) ? StDrain : StRead;
                    end
                end
            end
            StRead: begin
                if (room) begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = nxt_addr_q;
                    nxt_addr_d = nxt_addr_q + AddrOne;
                    rem_d      = rem_q - CntOne;
                    last_s1_d  = (rem_q == CntOne);
                    if (rem_q == CntOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!rom_en_q && !s2_q && (cnt_d == 3'd0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            nxt_addr_q <= '0;
            rem_q      <= '0;
            last_s1_q  <= 1'b0;
            s2_q       <= 1'b0;
            last_s2_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            nxt_addr_q <= nxt_addr_d;
            rem_q      <= rem_d;
            last_s1_q  <= last_s1_d;
            s2_q       <= s2_d;
            last_s2_q  <= last_s2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = (cnt_q != 3'd0);
    assign out_data  = head[DATA_W-1:0];
    assign out_last  = head[DATA_W];
`ifdef ROM_READER_PARITY_EN
    assign out_parity = head[DATA_W+1];
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: identity-content ROM, a queue-based block model checked every cycle,
// plus directed scenarios with literal cycle-accurate expectations.
module tb_rom_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] start_addr = '0;
    logic [4:0] count = '0;
    logic       busy, done, rom_en;
    logic [3:0] rom_addr;
    logic [3:0] rom_data = '0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
`ifdef ROM_READER_PARITY_EN
    logic       out_parity;
`endif

    rom_reader #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
`ifdef ROM_READER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: word at address a is a.
    always @(posedge clk) if (rom_en) rom_data <= rom_addr;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Block model: every accepted start enqueues the addresses to read and the words to emit.
    logic [3:0] exp_addr_q[$];
    logic [4:0] exp_out_q[$];
    logic [4:0] e;
    logic [3:0] wa;
    bit         busy_m = 1'b0;
    bit         done_m = 1'b0;
    bit         busy_nx, done_nx;
    bit         prev_rst = 1'b1;
    int         issued = 0;
    int         popped = 0;
    int         en_cycles = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_addr_q.delete();
            exp_out_q.delete();
            busy_m   = 1'b0;
            done_m   = 1'b0;
            issued   = 0;
            popped   = 0;
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_rom_en", rom_en, 0);
                chk("rst_rom_addr", rom_addr, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_out_last", out_last, 0);
`ifdef ROM_READER_PARITY_EN
                chk("rst_out_parity", out_parity, 0);
`endif
            end
            prev_rst = 1'b0;
            done_nx  = 1'b0;
            busy_nx  = busy_m;
            chk("busy", busy, busy_m);
            chk("done", done, done_m);
            if (rom_en) en_cycles++;
            if (exp_addr_q.size() == 0) begin
                chk("rom_en_nothing_left", rom_en, 0);
            end else if (rom_en) begin
                issued++;
                chk("rom_addr", rom_addr, exp_addr_q.pop_front());
                chk("in_flight_le_4", (issued - popped) <= 4, 1);
            end
            if (exp_out_q.size() == 0) begin
                chk("out_valid_nothing_left", out_valid, 0);
            end else if (out_valid && out_ready) begin
                e = exp_out_q.pop_front();
                chk("out_data", out_data, e[3:0]);
                chk("out_last", out_last, e[4]);
`ifdef ROM_READER_PARITY_EN
                chk("out_parity", out_parity, ^e[3:0]);
`endif
                popped++;
                if (e[4]) done_nx = 1'b1;
            end
            if (done_m) busy_nx = 1'b0;
            if (start && !busy_m) begin
                for (int i = 0; i < int'(count); i++) begin
                    wa = start_addr + 4'(i);
                    exp_addr_q.push_back(wa);
                    exp_out_q.push_back({(i == int'(count) - 1), wa});
                end
                busy_nx = 1'b1;
                if (count == 5'd0) done_nx = 1'b1;
            end
            busy_m = busy_nx;
            done_m = done_nx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] a, input logic [4:0] n, output int t0);
        start      = 1'b1;
        start_addr = a;
        count      = n;
        t0         = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic samp_at(input int c);
        while (cyc < c) tick();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        tick();
        while ((busy || exp_out_q.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) chk("idle_timeout", busy, 0);
        tick();
        tick();
    endtask

    int t0, t1, nv;

    initial begin
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // Full 16-word block, no backpressure.
        do_start(4'd0, 5'd16, t0);
        samp_at(t0 + 1);
        chk("t1_rom_en_c1", rom_en, 1);
        chk("t1_busy_c1", busy, 1);
        samp_at(t0 + 2);
        chk("t1_valid_c2", out_valid, 0);
        nv = 0;
        for (int c = 3; c <= 18; c++) begin
            samp_at(t0 + c);
            nv += int'(out_valid);
            if (c == 3) chk("t1_first_word", out_data, 0);
            if (c == 18) begin
                chk("t1_last_word", out_data, 15);
                chk("t1_last_flag", out_last, 1);
            end
        end
        chk("t1_valid_run", nv, 16);
        samp_at(t0 + 19);
        chk("t1_done_c19", done, 1);
        wait_idle();

        // Wrap from 15 to 0.
        do_start(4'd14, 5'd4, t0);
        samp_at(t0 + 3);
        chk("t2_rom_addr_c3", rom_addr, 0);
        samp_at(t0 + 6);
        chk("t2_last_word", out_data, 1);
        chk("t2_last_flag", out_last, 1);
        wait_idle();

        // Backpressure: ready low for cycles 0..12.
        out_ready = 1'b0;
        t1 = en_cycles;
        do_start(4'd0, 5'd16, t0);
        samp_at(t0 + 12);
        chk("t3_issues_stalled", en_cycles - t1, 4);
        chk("t3_fifo_head", out_data, 0);
        chk("t3_fifo_valid", out_valid, 1);
        tick();
        out_ready = 1'b1;
        wait_idle();

        // Empty block.
        do_start(4'd7, 5'd0, t0);
        samp_at(t0 + 1);
        chk("t4_done_c1", done, 1);
        chk("t4_rom_en_c1", rom_en, 0);
        samp_at(t0 + 2);
        chk("t4_busy_c2", busy, 0);
        chk("t4_valid_c2", out_valid, 0);
        wait_idle();

        // Second start mid-block is ignored.
        do_start(4'd3, 5'd6, t0);
        while (cyc < t0 + 3) tick();
        start      = 1'b1;
        start_addr = 4'd9;
        count      = 5'd2;
        tick();
        start = 1'b0;
        samp_at(t0 + 8);
        chk("t5_last_word", out_data, 8);
        chk("t5_last_flag", out_last, 1);
        samp_at(t0 + 9);
        chk("t5_done", done, 1);
        wait_idle();

        // Reset during READ with two words buffered.
        out_ready = 1'b0;
        do_start(4'd0, 5'd16, t0);
        while (cyc < t0 + 4) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_fifo_before_rst", out_valid, 1);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_valid_after_rst", out_valid, 0);
        chk("t6_busy_after_rst", busy, 0);
        tick();
        do_start(4'd5, 5'd1, t1);
        samp_at(t1 + 3);
        chk("t6_word", out_data, 5);
        chk("t6_last", out_last, 1);
        chk("t6_valid", out_valid, 1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1);
    end

endmodule
